// File: rtl/coproc_scoreboard.sv
// coproc_scoreboard: issue/writeback controller for a multi-cycle coprocessor with a
// RAW/WAW scoreboard, in-order tag FIFO and register-file write-port arbitration.
module coproc_scoreboard #(
  parameter int DEPTH        = 4,
  parameter int REG_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_D,
  input  logic [REG_W-1:0]    RdD,
  input  logic [REG_W-1:0]    Rs1D,
  input  logic [REG_W-1:0]    Rs2D,
  input  logic                StallD_in,
  input  logic                FlushD,
  input  logic                RegwriteW,
  input  logic                cp_ready,
  output logic                cp_start,
  output logic [REG_W-1:0]    cp_rd,
  input  logic                cp_done,
  output logic                cp_ack,
  output logic                wb_sel,
  output logic [REG_W-1:0]    wb_rd,
  output logic                sb_stall,
  output logic [2**REG_W-1:0] pending,
  output logic [REG_W:0]      count,
  output logic                err
);
  localparam int NR = 2**REG_W;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [REG_W-1:0] r_fifo [DEPTH];
  logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [NR-1:0]    r_pending;
  logic [REG_W:0]   r_count;
  logic [SW-1:0]    r_starve;
  logic             r_err;
  logic             w_haz, w_res_stall, w_starve_stall, w_fire, w_nonempty;
  logic [NR-1:0]    w_set, w_clr;
  assign w_nonempty     = r_count != '0;
  // the RdD term is the WAW guard: no two in-flight ops ever share a nonzero rd
  assign w_haz          = (Rs1D != '0 && r_pending[Rs1D]) || (Rs2D != '0 && r_pending[Rs2D]) ||
                          (RdD != '0 && r_pending[RdD]);
  assign w_res_stall    = issue_D && (r_count == (REG_W+1)'(DEPTH) || !cp_ready);
  assign w_starve_stall = r_starve >= SW'(STARVE_LIMIT);
  assign sb_stall       = w_haz || w_res_stall || w_starve_stall;
  assign w_fire         = issue_D && !sb_stall && !StallD_in && !FlushD;
  assign cp_start       = w_fire;
  assign cp_rd          = RdD;
  assign cp_ack         = cp_done && !RegwriteW && w_nonempty;
  assign wb_sel         = cp_ack;
  assign wb_rd          = r_fifo[r_rd_ptr];
  assign pending        = r_pending;
  assign count          = r_count;
  assign err            = r_err;
  assign w_set          = (w_fire && RdD != '0) ? NR'(1) << RdD : '0;
  assign w_clr          = cp_ack ? NR'(1) << wb_rd : '0;
  always_ff @(posedge clk)
    if (w_fire) r_fifo[r_wr_ptr] <= RdD;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_pending <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_wr_ptr  <= w_fire ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr  <= cp_ack ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count   <= (w_fire && !cp_ack) ? r_count + 1'b1 :
                   (cp_ack && !w_fire) ? r_count - 1'b1 : r_count;
      r_starve  <= (cp_ack || !cp_done) ? '0 :
                   (RegwriteW && w_nonempty && !w_starve_stall) ? r_starve + 1'b1 : r_starve;
      if (cp_done && !w_nonempty) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_coproc_scoreboard.sv
// tb_coproc_scoreboard: directed vectors plus a queue-based reference model checked every cycle.
module tb_coproc_scoreboard;
  localparam int DEPTH = 4, REG_W = 3, STARVE_LIMIT = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_D = 0, StallD_in = 0, FlushD = 0, RegwriteW = 0, cp_ready = 0, cp_done = 0;
  logic [REG_W-1:0] RdD = 0, Rs1D = 0, Rs2D = 0;
  logic cp_start, cp_ack, wb_sel, sb_stall, err;
  logic [REG_W-1:0] cp_rd, wb_rd;
  logic [2**REG_W-1:0] pending;
  logic [REG_W:0] count;
  int vectors = 0, miscompares = 0;
  logic [REG_W-1:0] mq[$];
  int m_starve = 0;
  bit m_err = 0;

  coproc_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .issue_D(issue_D), .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .StallD_in(StallD_in), .FlushD(FlushD), .RegwriteW(RegwriteW), .cp_ready(cp_ready),
    .cp_start(cp_start), .cp_rd(cp_rd), .cp_done(cp_done), .cp_ack(cp_ack), .wb_sel(wb_sel),
    .wb_rd(wb_rd), .sb_stall(sb_stall), .pending(pending), .count(count), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin : model
    logic [2**REG_W-1:0] ep;
    bit eh, est, efire, eack;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_err = 0;
      chk("m_rst_pending", pending, 0);
      chk("m_rst_count", count, 0);
      chk("m_rst_err", err, 0);
    end else begin
      ep = '0;
      foreach (mq[i]) if (mq[i] != 0) ep[mq[i]] = 1'b1;
      eh = (Rs1D != 0 && ep[Rs1D]) || (Rs2D != 0 && ep[Rs2D]) || (RdD != 0 && ep[RdD]);
      est = eh || (issue_D && (mq.size() == DEPTH || !cp_ready)) || m_starve >= STARVE_LIMIT;
      efire = issue_D && !est && !StallD_in && !FlushD;
      eack = cp_done && !RegwriteW && mq.size() != 0;
      chk("m_pending", pending, ep);
      chk("m_count", count, mq.size());
      chk("m_err", err, m_err);
      chk("m_sb_stall", sb_stall, est);
      chk("m_cp_start", cp_start, efire);
      chk("m_cp_rd", cp_rd, RdD);
      chk("m_cp_ack", cp_ack, eack);
      chk("m_wb_sel", wb_sel, eack);
      if (mq.size() != 0) chk("m_wb_rd", wb_rd, mq[0]);
      if (cp_done && mq.size() == 0) m_err = 1;
      if (eack || !cp_done) m_starve = 0;
      else if (RegwriteW && m_starve < STARVE_LIMIT) m_starve++;
      if (eack) void'(mq.pop_front());
      if (efire) mq.push_back(RdD);
    end
  end

  task automatic drive(input logic iss, input logic [REG_W-1:0] rd, rs1, rs2,
                       input logic stl, fl, rw, rdy, dn);
    issue_D = iss; RdD = rd; Rs1D = rs1; Rs2D = rs2;
    StallD_in = stl; FlushD = fl; RegwriteW = rw; cp_ready = rdy; cp_done = dn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("idle_cp_start", cp_start, 0); chk("idle_cp_ack", cp_ack, 0);
    chk("idle_wb_sel", wb_sel, 0); chk("idle_sb_stall", sb_stall, 0);
    chk("idle_pending", pending, 0); chk("idle_count", count, 0); chk("idle_err", err, 0);
    tick();
    drive(1, 3, 0, 0, 0, 0, 0, 1, 0);
    chk("single_start", cp_start, 1); chk("single_rd", cp_rd, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("single_pending", pending, 8'h08); chk("single_count", count, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("single_ack", cp_ack, 1); chk("single_wb_rd", wb_rd, 3); chk("single_wb_sel", wb_sel, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("single_pending0", pending, 0); chk("single_count0", count, 0);
    tick();
    drive(1, 3, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 3, 0, 0, 0, 0, 1, 0);
    chk("raw_stall", sb_stall, 1); tick();
    drive(0, 0, 0, 3, 0, 0, 0, 1, 0);
    chk("raw_rs2_stall", sb_stall, 1); tick();
    drive(1, 3, 0, 0, 0, 0, 0, 1, 0);
    chk("waw_stall", sb_stall, 1); chk("waw_start", cp_start, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("r0_no_stall", sb_stall, 0); tick();
    drive(0, 0, 3, 0, 0, 0, 0, 1, 1);
    chk("raw_ack", cp_ack, 1); chk("raw_stall_ackcyc", sb_stall, 1); tick();
    drive(0, 0, 3, 0, 0, 0, 0, 1, 0);
    chk("raw_release", sb_stall, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 4, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 5, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 7, 0, 0, 0, 0, 0, 1, 0);
    chk("full_count", count, 4); chk("full_pending", pending, 8'h36);
    chk("full_stall", sb_stall, 1); chk("full_start", cp_start, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("drain_rd1", wb_rd, 1); tick();
    drive(1, 6, 0, 0, 0, 0, 0, 1, 1);
    chk("both_start", cp_start, 1); chk("both_ack", cp_ack, 1); chk("drain_rd2", wb_rd, 2); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("both_count", count, 3); chk("both_pending", pending, 8'h70); chk("drain_rd4", wb_rd, 4); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("drain_rd5", wb_rd, 5); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("drain_rd6", wb_rd, 6); tick();
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_count", count, 0); chk("notready_stall", sb_stall, 1); chk("notready_start", cp_start, 0);
    tick();
    drive(1, 2, 0, 0, 0, 0, 0, 1, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
      chk("starve_ack", cp_ack, 0); chk("starve_stall", sb_stall, i == 5);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("starve_release_ack", cp_ack, 1); chk("starve_hold", sb_stall, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("starve_clear", sb_stall, 0); chk("starve_count", count, 0); tick();
    drive(1, 5, 0, 0, 0, 1, 0, 1, 0);
    chk("flush_start", cp_start, 0); tick();
    drive(1, 5, 0, 0, 1, 0, 0, 1, 0);
    chk("stalld_start", cp_start, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("gate_pending", pending, 0); chk("gate_count", count, 0); chk("err_no_ack", cp_ack, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("err_set", err, 1); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("pre_rst_count", count, 2); chk("pre_rst_pending", pending, 8'h06);
    rst = 1;
    #1;
    chk("arst_pending", pending, 0); chk("arst_count", count, 0); chk("arst_err", err, 0);
    tick();
    rst = 0;
    drive(1, 3, 0, 0, 0, 0, 0, 1, 0);
    chk("post_rst_start", cp_start, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("post_rst_count", count, 1); tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
